// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared state encoding, channel constants and one-hot helper
package demux_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {IDLE, SEEK, XFER, DRAIN} state_t;

  function automatic logic [NUM_CH-1:0] onehot8(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_next_sel.sv
// rtl/rr_next_sel.sv - combinational round-robin picker: lowest enabled index strictly after ptr
module rr_next_sel
  import demux_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  next,
  output logic              found,
  output logic              wrap
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    next  = ptr;
    found = 1'b0;
    cand  = '0;
    // Last candidate is ptr itself, so a lone enabled channel re-selects itself
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = ptr + SEL_W'(i);
      if (!found && mask[cand]) begin
        next  = cand;
        found = 1'b1;
      end
    end
    wrap = found && (next <= ptr);
  end

endmodule

// File: rtl/demux_burst_sched.sv
// rtl/demux_burst_sched.sv - round-robin burst scheduler owning the 1-to-8 demux select
// DEMUX_TIMEOUT_EN adds the TIMEOUT parameter, timeout_err port and XFER idle abort.
module demux_burst_sched
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BURST  = 4
`ifdef DEMUX_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] ch_ready,
  output logic [NUM_CH-1:0] out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              frame_done
`ifdef DEMUX_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  localparam logic [7:0] BURST_C = 8'(BURST);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d, ptr_q, ptr_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [NUM_CH-1:0] out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  rr_next;
  logic              rr_found, rr_wrap;
  logic              complete, accept;

`ifdef DEMUX_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            timeout_err_q, timeout_err_d;
  assign timeout_err = timeout_err_q;
`endif

  rr_next_sel u_rr_next_sel (
    .mask  (ch_mask),
    .ptr   (ptr_q),
    .next  (rr_next),
    .found (rr_found),
    .wrap  (rr_wrap)
  );

  // ch_ready reaches only in_ready; every out_* comes straight from a flop
  assign complete   = out_valid_q[sel_q] && ch_ready[sel_q];
  assign in_ready   = (state_q == XFER) && (!(|out_valid_q) || ch_ready[sel_q]);
  assign accept     = in_valid && in_ready;
  assign frame_done = (state_q == SEEK) && enable && rr_found && rr_wrap;
  assign busy       = (state_q != IDLE);
  assign sel        = sel_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (enable && (|ch_mask)) state_d = SEEK;
      end
      SEEK: begin
        if (enable && rr_found) begin
          sel_d      = rr_next;
          ptr_d      = rr_next;
          beat_cnt_d = '0;
          state_d    = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (complete) out_valid_d = '0;
        if (accept) begin
          out_data_d  = in_data;
          out_valid_d = onehot8(sel_q);
          beat_cnt_d  = beat_cnt_q + 8'd1;
          if (beat_cnt_q + 8'd1 == BURST_C) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (complete) out_valid_d = '0;
        if (complete || !(|out_valid_q)) state_d = enable ? SEEK : IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef DEMUX_TIMEOUT_EN
    timeout_err_d = 1'b0;
    idle_cnt_d    = '0;
    if (state_q == XFER && !accept) begin
      if (idle_cnt_q == TO_LAST) begin
        timeout_err_d = 1'b1;
        state_d       = DRAIN;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      ptr_q         <= SEL_W'(NUM_CH - 1);
      beat_cnt_q    <= '0;
      out_valid_q   <= '0;
      out_data_q    <= '0;
`ifdef DEMUX_TIMEOUT_EN
      idle_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      ptr_q         <= ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
`ifdef DEMUX_TIMEOUT_EN
      idle_cnt_q    <= idle_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

endmodule

// File: doc/demux_burst_sched.md
Name: demux_burst_sched

Overview:
Round-robin burst scheduler that drives the 1-to-8 demux select and registered output stage. It distributes a single valid/ready input stream across 8 output channels. Each enabled channel receives BURST beats in turn, with per-channel backpressure honoured. It sits between a single-source producer and eight consumer lanes, and owns the demux select.

Parameters:
DATA_W, 8, width of data word
BURST, 4, beats delivered per channel visit (1..255)
TIMEOUT, 16, idle cycles before burst abort (used only with DEMUX_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  level; scheduler runs while high
ch_mask  input  8  channel enables, bit i = channel i
in_valid  input  1  producer word valid
in_data  input  DATA_W  producer word
in_ready  output  1  scheduler accepts word this cycle
ch_ready  input  8  per-channel consumer ready
out_valid  output  8  one-hot registered valid, bit = current channel
out_data  output  DATA_W  registered data, shared by all channels
sel  output  3  current channel index
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse when round-robin wraps

Behaviour:
- Reset (async, rst_n low): state=IDLE; sel=0; out_valid=0; out_data=0; in_ready=0; busy=0; frame_done=0; beat_cnt=0; internal ptr=7, so the first seek starts at channel 0.
- States: IDLE, SEEK, XFER, DRAIN.
- IDLE -> SEEK when enable=1 and ch_mask!=0.
- SEEK (exactly 1 cycle):
  - Picks the lowest enabled index strictly after ptr, modulo 8, from ch_mask sampled this cycle.
  - Loads sel and ptr with that index; clears beat_cnt; goes to XFER.
  - If the chosen index <= old ptr (wrap), frame_done pulses in this same cycle.
  - A single enabled channel re-selects itself and pulses frame_done on every visit.
  - If ch_mask==0 or enable==0 in SEEK, goes to IDLE with no pulse.
- XFER:
  - in_ready = !(|out_valid) || ch_ready[sel], i.e. a one-deep output register.
  - An output beat completes when out_valid[sel] && ch_ready[sel]; out_valid clears unless refilled the same cycle.
  - An accept occurs when in_valid && in_ready: the output register loads in_data, out_valid is set to one-hot(sel), and beat_cnt increments.
  - Accept and output completion in the same cycle: register replaced, no bubble.
  - When beat_cnt reaches BURST on an accept, go to DRAIN.
- DRAIN:
  - in_ready=0.
  - Waits for the last beat to complete, then goes to SEEK, or to IDLE if enable=0.
  - The next SEEK may begin in the cycle after completion.
- ch_mask changes mid-burst take effect only at the next SEEK. The current burst always completes.
- enable deasserting mid-burst: the current burst completes (XFER then DRAIN), then IDLE.
- sel is stable from SEEK exit until the next SEEK. out_valid never has a bit other than bit sel set.
- busy = (state != IDLE).
- Latency: in_data appears on out_data 1 cycle after accept.
- No combinational path from ch_ready to out_*. ch_ready feeds only in_ready.

Optional Feature:
DEMUX_TIMEOUT_EN:
- Defined:
  - Adds output port timeout_err (1 bit) and an idle counter that runs in XFER.
  - The counter clears on any accept.
  - When it reaches TIMEOUT with no accept, the burst is abandoned: go to DRAIN, pulse timeout_err for 1 cycle, reset the counter.
  - An already-registered beat is still delivered.
- Undefined: no port, no counter; XFER waits indefinitely.

Decomposition:
- Package demux_pkg holds:
  - state enum (IDLE, SEEK, XFER, DRAIN)
  - NUM_CH=8 and SEL_W=3 constants
  - function onehot8(sel)
- One sub-module: rr_next_sel. It is combinational: inputs mask[7:0] and ptr[2:0], outputs next[2:0], found, wrap. It is instantiated once for SEEK.

Test Plan:
- Reset mid-XFER with out_valid=8'h04: on assertion all outputs go 0 immediately; after release the first visit is channel 0.
- Mask 8'hFF, BURST=4, in_valid and ch_ready all held 1: 4 beats per channel, order 0..7; frame_done pulses once per 32-beat round, on the SEEK selecting channel 0.
- Mask 8'b1010_0100: visits 2, 5, 7, 2; frame_done on each SEEK back to 2; sel never equals 0, 1, 3, 4 or 6.
- ch_ready[3]=0 for 5 cycles while sel=3 with a beat held: in_ready=0, out_data is held stable, no beat is lost or duplicated; on release, throughput resumes at 1 beat/cycle.
- Mask changed from 8'h0F to 8'hF0 during channel 1's burst: channel 1 completes 4 beats, then channel 4 is next. enable dropped mid-burst: burst finishes, then IDLE with busy=0.
- DEMUX_TIMEOUT_EN, TIMEOUT=16: in_valid=0 for 16 cycles in XFER gives a timeout_err pulse, then DRAIN, then SEEK to the next channel; without the macro the scheduler stays in XFER.
